// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: Wishbone classic bus bundle; master modport drives the request, slave modport answers.
interface wb_arbiter2_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        rty;
  modport master(output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err, rty);
  modport slave(input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master Wishbone classic arbiter, ownership held per cyc.
// Define WB_ARBITER2_TIMEOUT_EN to add a watchdog that errors out stalled strobes.
module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);
  typedef enum logic [1:0] {NONE, M0, M1} owner_t;
  owner_t owner_q, owner_d, grant;
  logic last_q, last_d;
  logic own0, own1, own_cyc, live, stb, abort;
  always_comb begin
    own0 = owner_q == M0;
    own1 = owner_q == M1;
    own_cyc = (own0 && m0.cyc) || (own1 && m1.cyc);
    grant = (m0.cyc && m1.cyc) ? (last_q ? M0 : M1) : m0.cyc ? M0 : m1.cyc ? M1 : NONE;
    owner_d = own_cyc ? owner_q : grant;
    last_d = (!own_cyc && grant != NONE) ? (grant == M1) : last_q;
    live = own_cyc && !abort;
    stb = live && (own0 ? m0.stb : m1.stb);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      owner_q <= NONE;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  assign s.cyc   = live;
  assign s.stb   = stb;
  assign s.we    = own0 ? m0.we : own1 && m1.we;
  assign s.adr   = own0 ? m0.adr : own1 ? m1.adr : '0;
  assign s.sel   = own0 ? m0.sel : own1 ? m1.sel : '0;
  assign s.dat_w = own0 ? m0.dat_w : own1 ? m1.dat_w : '0;
  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0.dat_r = (own0 || own1) ? s.dat_r : '0;
  assign m1.dat_r = (own0 || own1) ? s.dat_r : '0;
  assign m0.ack = own0 && live && s.ack;
  assign m1.ack = own1 && live && s.ack;
  assign m0.err = own0 && ((live && s.err) || abort);
  assign m1.err = own1 && ((live && s.err) || abort);
  assign m0.rty = own0 && live && s.rty;
  assign m1.rty = own1 && live && s.rty;
`ifdef WB_ARBITER2_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  assign abort = own_cyc && tmo_cnt_q == 16'(TIMEOUT_CYCLES);
  // The abort cycle forces stb low, so the counter restarts by itself.
  always_comb
    tmo_cnt_d = (owner_d != owner_q || !stb || s.ack || s.err || s.rty) ? '0 : tmo_cnt_q + 16'd1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) tmo_cnt_q <= '0;
    else tmo_cnt_q <= tmo_cnt_d;
`else
  logic unused_tmo;
  assign abort = 1'b0;
  assign unused_tmo = TIMEOUT_CYCLES == 0;
`endif
endmodule
